// File: rtl/bram_req_ctrl_pkg.sv
// Shared types for the block-RAM request controller: size encodings and the
// response FIFO entry layout.
package bram_req_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_entry_t;

endpackage

// File: rtl/bram_rsp_fifo.sv
// In-order circular response buffer with occupancy count; head is presented
// combinationally and reads as zero while empty.
module bram_rsp_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign empty   = (count == '0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bram_req_ctrl.sv
// Load/store front end for a byte-enabled single-port BRAM: checks each request,
// drives the RAM port on accept and returns one in-order response per request.
module bram_req_ctrl
    import bram_req_ctrl_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RSP_DEPTH = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [31:0]       mem_din,
    output logic [3:0]        mem_byte_en,
    input  logic [31:0]       mem_dout
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0] count;
    logic [CW:0]   occ;
    logic [31:0]   offset;
    logic          accept, req_err;
    logic          pending, pend_load, pend_err;
    logic          fifo_empty, deq;
    rsp_entry_t    enq_entry, head;

    // BASE_ADDR is window-aligned, so offset[1:0] equals the request's byte lane.
    assign offset = req_addr - BASE_ADDR;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SZ_B:    req_err = 1'b0;
            SZ_H:    req_err = offset[0];
            SZ_W:    req_err = |offset[1:0];
            default: req_err = 1'b1;
        endcase
        if (|offset[31:ADDR_W+2]) req_err = 1'b1;
    end

    // Credit check uses only registered state so req_ready has no path from rsp_ready.
    assign occ       = {1'b0, count} + (CW+1)'(pending);
    assign req_ready = !reset && (occ < (CW+1)'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    assign mem_oce = 1'b1;

    always_comb begin
        mem_ce      = 1'b0;
        mem_wre     = 1'b0;
        mem_ad      = '0;
        mem_din     = '0;
        mem_byte_en = '0;
        if (accept && !req_err) begin
            mem_ce  = 1'b1;
            mem_wre = req_wr;
            mem_ad  = offset[ADDR_W+1:2];
            case (req_size)
                SZ_B: begin
                    mem_din     = {NUM_LANES{req_wdata[7:0]}};
                    mem_byte_en = 4'b0001 << offset[1:0];
                end
                SZ_H: begin
                    mem_din     = {(NUM_LANES/2){req_wdata[15:0]}};
                    mem_byte_en = 4'b0011 << offset[1:0];
                end
                default: begin
                    mem_din     = req_wdata;
                    mem_byte_en = 4'b1111;
                end
            endcase
            if (!req_wr) mem_byte_en = 4'b0000;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            pend_load <= 1'b0;
            pend_err  <= 1'b0;
        end else begin
            pending   <= accept;
            pend_load <= accept && !req_wr;
            pend_err  <= accept && req_err;
        end
    end

    // RAM data is only meaningful for a clean load issued last cycle.
    assign enq_entry.rdata = (pending && pend_load && !pend_err) ? mem_dout : 32'h0;
    assign enq_entry.err   = pend_err;

    assign rsp_valid = !fifo_empty;
    assign deq       = rsp_valid && rsp_ready;

    bram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pending),
        .wr_data (enq_entry),
        .rd_en   (deq),
        .rd_data (head),
        .empty   (fifo_empty),
        .count   (count)
    );

    assign rsp_rdata = head.rdata;
    assign rsp_err   = head.err;

endmodule

// File: tb/tb_bram_req_ctrl.sv
// Directed and randomised checks of bram_req_ctrl against a behavioural BRAM
// and an independent reference memory.
module tb_bram_req_ctrl;
    import bram_req_ctrl_pkg::*;

    localparam int          ADDR_W = 11;
    localparam logic [31:0] BASE   = 32'h0001_0000;
    localparam int          DEPTH  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [1:0]        req_size = 2'd0;
    logic [31:0]       req_addr = '0, req_wdata = '0;
    logic              req_ready, rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_ce, mem_oce, mem_wre;
    logic [ADDR_W-1:0] mem_ad;
    logic [31:0]       mem_din, mem_dout;
    logic [3:0]        mem_byte_en;

    always #5 clk = ~clk;

    bram_req_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ce(mem_ce), .mem_oce(mem_oce), .mem_wre(mem_wre), .mem_ad(mem_ad),
        .mem_din(mem_din), .mem_byte_en(mem_byte_en), .mem_dout(mem_dout)
    );

    logic [31:0] ram     [0:2047];
    logic [31:0] ref_mem [0:2047];

    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_ce) begin
            if (mem_wre) begin
                w = ram[mem_ad];
                for (int b = 0; b < 4; b++)
                    if (mem_byte_en[b]) w[8*b +: 8] = mem_din[8*b +: 8];
                ram[mem_ad] <= w;
            end else begin
                mem_dout <= ram[mem_ad];
            end
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
               (off >= 32'h0000_2000);
    endfunction

    task automatic ref_apply(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                             input logic [31:0] d, output logic [31:0] er, output logic ee);
        logic [31:0] off;
        int w;
        off = a - BASE;
        w   = int'(off[12:2]);
        ee  = ref_err(sz, a);
        er  = '0;
        if (!ee) begin
            if (wr) begin
                case (sz)
                    2'd0:    ref_mem[w][8*a[1:0] +: 8]  = d[7:0];
                    2'd1:    ref_mem[w][8*a[1:0] +: 16] = d[15:0];
                    default: ref_mem[w] = d;
                endcase
            end else begin
                er = ref_mem[w];
            end
        end
    endtask

    logic              m_ce, m_wre;
    logic [ADDR_W-1:0] m_ad;
    logic [31:0]       m_din, x_rd;
    logic [3:0]        m_be;
    logic              x_err;

    // Present one request, wait for acceptance, capture the RAM strobe, then drop valid.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
        int n;
        n = 0;
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = d;
        #1;
        while (!req_ready && n < 50) begin
            cyc();
            n++;
        end
        chk("send_rdy", req_ready, 1'b1);
        m_ce = mem_ce; m_wre = mem_wre; m_ad = mem_ad; m_din = mem_din; m_be = mem_byte_en;
        ref_apply(wr, sz, a, d, x_rd, x_err);
        cyc();
        req_valid = 1'b0;
        #1;
    endtask

    // Expects an empty FIFO and rsp_ready high: response appears one edge later.
    task automatic recv(input string tag, input logic [31:0] ed, input logic ee);
        chk({tag, "_lat0"}, rsp_valid, 1'b0);
        cyc();
        chk({tag, "_vld"}, rsp_valid, 1'b1);
        chk({tag, "_rd"}, rsp_rdata, ed);
        chk({tag, "_err"}, rsp_err, ee);
        cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] q_d[$];
        logic        q_e[$];
        logic [31:0] er, off;
        logic        ee, a, acc_now;
        int          acc, got, issued, rcvd;

        for (int i = 0; i < 2048; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        mem_dout = '0;

        // reset state, with a request presented that must not reach the RAM
        req_valid = 1'b1; req_wr = 1'b1; req_size = SZ_W; req_addr = BASE; req_wdata = 32'h1111_2222;
        cyc(); cyc();
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_rvld", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_rerr", rsp_err, 1'b0);
        chk("rst_ce", mem_ce, 1'b0);
        chk("rst_be", mem_byte_en, 4'h0);
        chk("rst_oce", mem_oce, 1'b1);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_rel_ready", req_ready, 1'b1);
        rsp_ready = 1'b1;

        // word store / word load
        send(1'b1, SZ_W, BASE + 32'h10, 32'hDEAD_BEEF);
        chk("stw_ce", m_ce, 1'b1);
        chk("stw_wre", m_wre, 1'b1);
        chk("stw_ad", m_ad, 11'd4);
        chk("stw_be", m_be, 4'hF);
        chk("stw_din", m_din, 32'hDEAD_BEEF);
        recv("stw", 32'h0, 1'b0);
        send(1'b0, SZ_W, BASE + 32'h10, 32'h0);
        chk("ldw_wre", m_wre, 1'b0);
        chk("ldw_be", m_be, 4'h0);
        chk("ldw_ad", m_ad, 11'd4);
        recv("ldw", 32'hDEAD_BEEF, 1'b0);

        // byte and half stores
        send(1'b1, SZ_B, BASE + 32'h13, 32'h0000_00A5);
        chk("stb_be", m_be, 4'b1000);
        chk("stb_din", m_din, 32'hA5A5_A5A5);
        recv("stb", 32'h0, 1'b0);
        send(1'b0, SZ_W, BASE + 32'h10, 32'h0);
        recv("ldw_after_b", 32'hA5AD_BEEF, 1'b0);
        send(1'b1, SZ_H, BASE + 32'h16, 32'h5A5A_1234);
        chk("sth_be", m_be, 4'b1100);
        chk("sth_din", m_din, 32'h1234_1234);
        chk("sth_ad", m_ad, 11'd5);
        recv("sth", 32'h0, 1'b0);
        send(1'b0, SZ_W, BASE + 32'h14, 32'h0);
        recv("ldw_after_h", 32'h1234_0000, 1'b0);
        send(1'b0, SZ_B, BASE + 32'h11, 32'h0);
        chk("ldb_ce", m_ce, 1'b1);
        recv("ldb_raw", 32'hA5AD_BEEF, 1'b0);

        // error cases and window edge
        send(1'b1, SZ_H, BASE + 32'h1, 32'hFFFF_FFFF);
        chk("mis_h_ce", m_ce, 1'b0);
        recv("mis_h", 32'h0, 1'b1);
        send(1'b0, SZ_W, BASE + 32'h2, 32'h0);
        chk("mis_w_ce", m_ce, 1'b0);
        recv("mis_w", 32'h0, 1'b1);
        send(1'b0, 2'd3, BASE + 32'h20, 32'h0);
        chk("sz3_ce", m_ce, 1'b0);
        recv("sz3", 32'h0, 1'b1);
        send(1'b0, SZ_W, BASE + 32'h2000, 32'h0);
        chk("oow_ce", m_ce, 1'b0);
        recv("oow", 32'h0, 1'b1);
        send(1'b0, SZ_W, BASE - 32'h4, 32'h0);
        recv("below", 32'h0, 1'b1);
        send(1'b1, SZ_W, BASE + 32'h1FFC, 32'h0BAD_F00D);
        chk("top_ad", m_ad, 11'h7FF);
        chk("top_ce", m_ce, 1'b1);
        recv("top_st", 32'h0, 1'b0);
        send(1'b0, SZ_W, BASE + 32'h1FFC, 32'h0);
        recv("top_ld", 32'h0BAD_F00D, 1'b0);

        // backpressure: preload five words, then five loads with rsp_ready low
        for (int i = 0; i < 5; i++) begin
            send(1'b1, SZ_W, BASE + 32'h40 + 32'(4*i), 32'hC0DE_0000 + 32'(i));
            recv("bp_pre", 32'h0, 1'b0);
        end
        rsp_ready = 1'b0;
        acc = 0; got = 0;
        req_valid = 1'b1; req_wr = 1'b0; req_size = SZ_W; req_addr = BASE + 32'h40;
        #1;
        for (int c = 0; c < 6; c++) begin
            a = req_valid && req_ready;
            cyc();
            if (a) begin
                acc++;
                if (acc < 5) req_addr = BASE + 32'h40 + 32'(4*acc);
                else req_valid = 1'b0;
            end
            #1;
        end
        chk("bp_acc", acc, 3);
        chk("bp_rdy0", req_ready, 1'b0);
        rsp_ready = 1'b1;
        #1;
        chk("bp_nocomb", req_ready, 1'b0);
        for (int c = 0; c < 30 && (got < 5 || acc < 5); c++) begin
            a = req_valid && req_ready;
            if (rsp_valid) begin
                chk("bp_rd", rsp_rdata, 32'hC0DE_0000 + 32'(got));
                got++;
            end
            cyc();
            if (c == 0) chk("bp_rise", req_ready, 1'b1);
            if (a) begin
                acc++;
                if (acc < 5) req_addr = BASE + 32'h40 + 32'(4*acc);
                else req_valid = 1'b0;
            end
            #1;
        end
        chk("bp_got", got, 5);
        chk("bp_acc_all", acc, 5);

        // random traffic against the reference model
        issued = 0; rcvd = 0;
        req_valid = 1'b0;
        for (int c = 0; c < 3000 && rcvd < 100; c++) begin
            rsp_ready = 1'($urandom_range(0, 1));
            if (!req_valid && issued < 100) begin
                off = ($urandom_range(0, 7) == 0) ? 32'h1FF0 + 32'($urandom_range(0, 31))
                                                  : 32'($urandom_range(0, 63));
                req_valid = 1'b1;
                req_wr    = 1'($urandom_range(0, 1));
                req_size  = 2'($urandom_range(0, 3));
                req_addr  = BASE + off;
                req_wdata = $urandom;
            end
            #1;
            acc_now = 1'b0;
            if (rsp_valid && rsp_ready) begin
                if (q_d.size() == 0) chk("rnd_extra", q_d.size(), 1);
                else begin
                    chk("rnd_rd", rsp_rdata, q_d.pop_front());
                    chk("rnd_err", rsp_err, q_e.pop_front());
                end
                rcvd++;
            end
            if (req_valid && req_ready) begin
                ref_apply(req_wr, req_size, req_addr, req_wdata, er, ee);
                q_d.push_back(er);
                q_e.push_back(ee);
                issued++;
                acc_now = 1'b1;
            end
            cyc();
            if (acc_now) req_valid = 1'b0;
        end
        chk("rnd_issued", issued, 100);
        chk("rnd_rcvd", rcvd, 100);
        chk("rnd_left", q_d.size(), 0);

        // reset with two responses queued and one pending
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        cyc();
        send(1'b0, SZ_W, BASE + 32'h40, 32'h0);
        send(1'b0, SZ_W, BASE + 32'h44, 32'h0);
        send(1'b0, SZ_W, BASE + 32'h48, 32'h0);
        chk("mid_vld", rsp_valid, 1'b1);
        chk("mid_rd", rsp_rdata, 32'hC0DE_0000);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 1'b0);
        cyc();
        chk("mid_rst_vld", rsp_valid, 1'b0);
        chk("mid_rst_rd", rsp_rdata, 32'h0);
        chk("mid_rst_ready2", req_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rel_ready", req_ready, 1'b1);
        rsp_ready = 1'b1;
        send(1'b0, SZ_W, BASE + 32'h4C, 32'h0);
        recv("post_rst", 32'hC0DE_0003, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
